// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receiver: parity modes, FSM states and
// the bit-counter width helper.
package serial_rx_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_PAR   = 2'd2,
    ST_GUARD = 2'd3
  } rx_state_t;

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 2);
  endfunction

endpackage

// File: rtl/scl_edge_sync.sv
// Brings sSCL/sSDA into the system clock domain and flags sSCL falling edges.
// Flops reset high so the idle-high bus never looks like an edge after reset.
module scl_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_fe,
  output logic o_sda
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev <= r_scl_sync[SYNC_STAGES-1];
    end
  end

  // sda is taken from the same stage as the scl edge so both see equal delay
  assign o_fe  = r_scl_prev & ~r_scl_sync[SYNC_STAGES-1];
  assign o_sda = r_sda_sync[SYNC_STAGES-1];

endmodule

// File: rtl/serial_rx_deser.sv
// Serial-to-parallel receiver: assembles DATA_W-bit words on sSCL falling
// edges, checks parity and hands words out over a VALID/ACK handshake.
//   state    | meaning
//   IDLE     | receiver disabled, waiting for START
//   DATA     | shifting data bits, one per falling edge
//   PAR      | waiting for the parity bit
//   GUARD    | word delivered, consuming the guard edge
module serial_rx_deser
  import serial_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int MSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              sSDA,
  input  logic              sSCL,
  input  logic              START,
  input  logic              ACK,
  output logic [DATA_W-1:0] PROR,
  output logic              PARITY_BIT,
  output logic              PAR_ERR,
  output logic              VALID,
  output logic              OVERRUN,
  output logic              BUSY
);

  localparam int              CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam bit              HAS_PAR  = (PARITY_MODE != PAR_NONE);

  rx_state_t         r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift, w_shift_next, w_word;
  logic              w_fe, w_sda;
  logic              w_shift_en, w_complete, w_cnt_clr, w_pbit, w_perr;

  scl_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_scl (sSCL),
    .i_sda (sSDA),
    .o_fe  (w_fe),
    .o_sda (w_sda)
  );

  always_comb begin
    w_shift_next = r_shift;
    if (MSB_FIRST != 0) begin
      w_shift_next    = r_shift << 1;
      w_shift_next[0] = w_sda;
    end else begin
      w_shift_next           = r_shift >> 1;
      w_shift_next[DATA_W-1] = w_sda;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_complete   = 1'b0;
    w_cnt_clr    = 1'b0;
    w_word       = r_shift;
    w_pbit       = 1'b0;
    case (r_state)
      ST_IDLE: if (START) w_state_next = ST_DATA;
      ST_DATA: begin
        if (!START) begin
          w_state_next = ST_IDLE;
          w_cnt_clr    = 1'b1;
        end else if (w_fe) begin
          w_shift_en = 1'b1;
          if (r_cnt == LAST_BIT) begin
            if (HAS_PAR) begin
              w_state_next = ST_PAR;
            end else begin
              w_complete   = 1'b1;
              w_word       = w_shift_next;
              w_state_next = ST_GUARD;
            end
          end
        end
      end
      ST_PAR: begin
        if (!START) begin
          w_state_next = ST_IDLE;
          w_cnt_clr    = 1'b1;
        end else if (w_fe) begin
          w_complete   = 1'b1;
          w_pbit       = w_sda;
          w_state_next = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (!START || w_fe) begin
          w_state_next = START ? ST_DATA : ST_IDLE;
          w_cnt_clr    = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_perr = 1'b0;
    if (PARITY_MODE == PAR_EVEN)     w_perr = ^w_word ^ w_pbit;
    else if (PARITY_MODE == PAR_ODD) w_perr = ~(^w_word ^ w_pbit);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      PROR       <= '0;
      PARITY_BIT <= 1'b0;
      PAR_ERR    <= 1'b0;
      VALID      <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      if (w_cnt_clr)       r_cnt <= '0;
      else if (w_shift_en) r_cnt <= r_cnt + 1'b1;
      if (w_shift_en) r_shift <= w_shift_next;
      if (w_complete) begin
        PROR       <= w_word;
        PARITY_BIT <= w_pbit;
        PAR_ERR    <= w_perr;
        VALID      <= 1'b1;
        // overwriting an unacknowledged word is an overrun unless ACK lands now
        OVERRUN    <= ~ACK & (VALID | OVERRUN);
      end else if (ACK && VALID) begin
        VALID   <= 1'b0;
        OVERRUN <= 1'b0;
      end
    end
  end

  assign BUSY = (r_state == ST_PAR) || (r_state == ST_GUARD) ||
                ((r_state == ST_DATA) && (r_cnt != '0));

endmodule

// File: tb/tb_serial_rx_deser.sv
// Bench for serial_rx_deser: an 8-bit even/LSB-first and a 12-bit odd/MSB-first
// instance, directed frames plus random frames checked against a word-level model.
module tb_serial_rx_deser;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sda, scl, start, ack;
  logic [7:0]  pror8;
  logic [11:0] pror12;
  logic [1:0]  pbit, perr, valid, ovr, busy;

  int n_chk = 0;
  int n_err = 0;

  int W [2]   = '{8, 12};
  int PM [2]  = '{1, 2};
  bit MSB [2] = '{1'b0, 1'b1};

  logic [15:0] m_word [2];
  bit          m_pbit [2];
  bit          m_perr [2];
  bit          m_valid [2];
  bit          m_ovr [2];

  always #5 clk = ~clk;

  serial_rx_deser #(.DATA_W(8), .PARITY_MODE(1), .MSB_FIRST(0), .SYNC_STAGES(2)) u_dut8 (
    .CLK(clk), .RST(rst), .sSDA(sda[0]), .sSCL(scl[0]), .START(start[0]), .ACK(ack[0]),
    .PROR(pror8), .PARITY_BIT(pbit[0]), .PAR_ERR(perr[0]), .VALID(valid[0]),
    .OVERRUN(ovr[0]), .BUSY(busy[0])
  );

  serial_rx_deser #(.DATA_W(12), .PARITY_MODE(2), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut12 (
    .CLK(clk), .RST(rst), .sSDA(sda[1]), .sSCL(scl[1]), .START(start[1]), .ACK(ack[1]),
    .PROR(pror12), .PARITY_BIT(pbit[1]), .PAR_ERR(perr[1]), .VALID(valid[1]),
    .OVERRUN(ovr[1]), .BUSY(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  function automatic logic [15:0] get_pror(input int sel);
    return (sel == 0) ? 16'(pror8) : 16'(pror12);
  endfunction

  task automatic check_all(input int sel, input string tag);
    chk({tag, "_pror"},  32'(get_pror(sel)), 32'(m_word[sel]));
    chk({tag, "_pbit"},  32'(pbit[sel]),  32'(m_pbit[sel]));
    chk({tag, "_perr"},  32'(perr[sel]),  32'(m_perr[sel]));
    chk({tag, "_valid"}, 32'(valid[sel]), 32'(m_valid[sel]));
    chk({tag, "_ovr"},   32'(ovr[sel]),   32'(m_ovr[sel]));
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_word[s] = '0; m_pbit[s] = 0; m_perr[s] = 0; m_valid[s] = 0; m_ovr[s] = 0;
    end
  endtask

  // one sSCL low pulse; on the completing edge also check the output latency
  task automatic fall_edge(input int sel, input bit b, input bit last, input bit ack_now,
                           input string tag);
    sda[sel] = b;
    ticks(2);
    scl[sel] = 1'b0;
    ticks(2);
    if (last) begin
      chk({tag, "_pre_valid"}, 32'(valid[sel]), 32'(m_valid[sel]));
      chk({tag, "_pre_pror"},  32'(get_pror(sel)), 32'(m_word[sel]));
    end
    if (ack_now) ack[sel] = 1'b1;
    ticks(1);
    ack[sel] = 1'b0;
    ticks(2);
    scl[sel] = 1'b1;
    ticks(3);
  endtask

  task automatic send_frame(input int sel, input logic [15:0] word, input bit p,
                            input bit ack_c, input string tag);
    int          n;
    bit          b;
    bit          has_par;
    logic [15:0] e;
    int          ones;
    n       = W[sel];
    has_par = (PM[sel] != 0);
    e       = '0;
    for (int i = 0; i < n; i++) begin
      b = MSB[sel] ? word[n-1-i] : word[i];
      // expected word rebuilt from bit arrival order alone
      if (b) e = e + 16'(1 << (MSB[sel] ? (n - 1 - i) : i));
      fall_edge(sel, b, (i == n - 1) && !has_par, ack_c && (i == n - 1) && !has_par, tag);
      if (i == 0) chk({tag, "_busy_first"}, 32'(busy[sel]), 32'd1);
    end
    if (has_par) fall_edge(sel, p, 1'b1, ack_c, tag);
    ones = $countones(e) + (has_par ? int'(p) : 0);
    m_pbit[sel] = has_par ? p : 1'b0;
    if (PM[sel] == 1)      m_perr[sel] = (ones % 2) != 0;
    else if (PM[sel] == 2) m_perr[sel] = (ones % 2) == 0;
    else                   m_perr[sel] = 1'b0;
    if (ack_c)             m_ovr[sel] = 1'b0;
    else if (m_valid[sel]) m_ovr[sel] = 1'b1;
    m_valid[sel] = 1'b1;
    m_word[sel]  = e;
    check_all(sel, tag);
    fall_edge(sel, 1'($urandom_range(0, 1)), 1'b0, 1'b0, tag);
    chk({tag, "_busy_guard"}, 32'(busy[sel]), 32'd0);
  endtask

  task automatic do_ack(input int sel, input string tag);
    ack[sel] = 1'b1;
    ticks(1);
    ack[sel] = 1'b0;
    if (m_valid[sel]) begin
      m_valid[sel] = 1'b0;
      m_ovr[sel]   = 1'b0;
    end
    chk({tag, "_ack_valid"}, 32'(valid[sel]), 32'(m_valid[sel]));
    chk({tag, "_ack_ovr"},   32'(ovr[sel]),   32'(m_ovr[sel]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          sel;
    logic [15:0] w;
    rst = 1'b1; scl = 2'b11; sda = 2'b11; start = 2'b00; ack = 2'b00;
    model_reset();
    ticks(3);
    rst = 1'b0;
    check_all(0, "rst8");
    check_all(1, "rst12");
    chk("rst_busy", 32'(busy), 32'd0);
    start = 2'b11;
    ticks(2);

    send_frame(0, 16'hA5, 1'b0, 1'b0, "a5_p0");
    send_frame(0, 16'hA5, 1'b1, 1'b0, "a5_p1");
    do_ack(0, "a5");

    send_frame(1, 16'hABC, 1'b0, 1'b0, "abc_p0");
    do_ack(1, "abc0");
    send_frame(1, 16'hABC, 1'b1, 1'b0, "abc_p1");
    do_ack(1, "abc1");

    for (int i = 0; i < 3; i++) fall_edge(0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "abort");
    chk("abort_busy_pre", 32'(busy[0]), 32'd1);
    start[0] = 1'b0;
    ticks(1);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    check_all(0, "abort");
    ticks(2);
    start[0] = 1'b1;
    ticks(2);
    send_frame(0, 16'h3C, 1'b0, 1'b0, "f3c");
    do_ack(0, "f3c");

    send_frame(0, 16'h11, 1'b0, 1'b0, "f11");
    send_frame(0, 16'h22, 1'b0, 1'b0, "f22");
    send_frame(0, 16'h33, 1'b0, 1'b1, "f33");
    do_ack(0, "f33");

    for (int i = 0; i < 5; i++) fall_edge(0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "rstmid");
    rst = 1'b1;
    ticks(1);
    rst = 1'b0;
    model_reset();
    check_all(0, "rstmid");
    chk("rstmid_busy", 32'(busy[0]), 32'd0);
    ticks(3);
    send_frame(0, 16'h5A, 1'b0, 1'b0, "f5a");
    do_ack(0, "f5a");

    for (int k = 0; k < 12; k++) begin
      sel = int'($urandom_range(0, 1));
      w   = 16'($urandom) & 16'((1 << W[sel]) - 1);
      send_frame(sel, w, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), "rnd");
      if ($urandom_range(0, 1) == 1) do_ack(sel, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
